// File: rtl/sobel_column_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_column_feeder_pkg
// Description : Shared definitions for the Sobel column feeder: default pixel
//               width, FILL/STREAM state encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_column_feeder_pkg;

   // Default pixel width, also used by the downstream Sobel consumer
   localparam int DATA_W_DEF = 8;

   // FILL: priming the two line buffers (rows 0..1); STREAM: emitting triples
   typedef enum logic [0:0] {
      FILL   = 1'b0,
      STREAM = 1'b1
   } feeder_state_t;

   // Counter width able to hold 0..v-1, never narrower than one bit
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_column_feeder_line_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ram
// Description : Single-port line buffer, one word per column. The read port
//               shows the stored word, so a write in the same cycle returns
//               the old contents (read-before-write); the new word is visible
//               from the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_ram #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Commit the write on the clock edge; contents are never cleared
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sobel_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sobel_column_feeder
// Description : Turns a raster pixel stream into vertical 3-pixel columns
//               (row r-1, r, r+1) for centre rows 1..IMG_H-2, using two line
//               buffers, a column/row counter, a FILL/STREAM FSM and a
//               stallable output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_column_feeder
   import sobel_column_feeder_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_in_valid,
   input  logic              pix_in_sof,
   output logic              pix_in_ready,
   output logic [DATA_W-1:0] left_out,
   output logic [DATA_W-1:0] current_out,
   output logic [DATA_W-1:0] right_out,
   output logic              window_valid,
   input  logic              window_ready,
   output logic              line_end,
   output logic              sync_err
);

   localparam int CW = clog2_min1(IMG_W);
   localparam int RW = clog2_min1(IMG_H);
   localparam logic [CW-1:0] c_col_last  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_row_last  = RW'(IMG_H - 1);
   localparam logic [RW-1:0] c_row_prime = RW'(1);

   logic [CW-1:0]     r_col, w_col_eff;
   logic [RW-1:0]     r_row, w_row_eff;
   feeder_state_t     r_state, w_state_eff, w_state_nxt;
   logic              w_acc, w_sof_acc, w_load, w_col_wrap;
   logic [DATA_W-1:0] w_lba_rdata, w_lbb_rdata;
   logic [DATA_W-1:0] r_left, r_current, r_right;
   logic              r_window_valid, r_line_end, r_sync_err;

   // A new pixel is taken whenever the output slot is free or being drained
   assign pix_in_ready = !rst && (!r_window_valid || window_ready);
   assign w_acc        = pix_in_valid && pix_in_ready;
   assign w_sof_acc    = w_acc && pix_in_sof;

   // An accepted SOF pixel is pixel (0,0) regardless of where the counters were
   assign w_col_eff   = w_sof_acc ? '0   : r_col;
   assign w_row_eff   = w_sof_acc ? '0   : r_row;
   assign w_state_eff = w_sof_acc ? FILL : r_state;
   assign w_col_wrap  = (w_col_eff == c_col_last);

   // lbA holds row r-2, lbB holds row r-1; each accept shifts the column up
   line_buffer_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb_a (
      .clk     (clk),
      .i_addr  (w_col_eff),
      .i_we    (w_acc),
      .i_wdata (w_lbb_rdata),
      .o_rdata (w_lba_rdata)
   );

   line_buffer_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb_b (
      .clk     (clk),
      .i_addr  (w_col_eff),
      .i_we    (w_acc),
      .i_wdata (pix_in),
      .o_rdata (w_lbb_rdata)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and window-load decision for the accepted pixel
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      if (w_acc) begin
         w_state_nxt = w_state_eff;
         case (w_state_eff)
            FILL: begin
               if (w_row_eff == c_row_prime && w_col_wrap) begin
                  w_state_nxt = STREAM;
               end
            end
            STREAM: begin
               w_load = 1'b1;
               if (w_row_eff == c_row_last && w_col_wrap) begin
                  w_state_nxt = FILL;
               end
            end
            default: w_state_nxt = FILL;
         endcase
      end
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_acc) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (w_row_eff == c_row_last) ? '0 : w_row_eff + 1'b1;
         end else begin
            r_col <= w_col_eff + 1'b1;
            r_row <= w_row_eff;
         end
      end
   end

   // Sticky flag: an SOF arrived while the counters were mid-frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_err <= 1'b0;
      end else if (w_sof_acc && (r_col != '0 || r_row != '0)) begin
         r_sync_err <= 1'b1;
      end
   end

   // Output register: load on a streamed pixel, hold on stall, clear on drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_left         <= '0;
         r_current      <= '0;
         r_right        <= '0;
         r_window_valid <= 1'b0;
         r_line_end     <= 1'b0;
      end else if (w_load) begin
         r_left         <= w_lba_rdata;
         r_current      <= w_lbb_rdata;
         r_right        <= pix_in;
         r_window_valid <= 1'b1;
         r_line_end     <= w_col_wrap;
      end else if (window_ready) begin
         r_window_valid <= 1'b0;
         r_line_end     <= 1'b0;
      end
   end

   assign left_out     = r_left;
   assign current_out  = r_current;
   assign right_out    = r_right;
   assign window_valid = r_window_valid;
   assign line_end     = r_line_end;
   assign sync_err     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_sobel_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_column_feeder
// Description : Directed self-checking bench for sobel_column_feeder with a
//               4x4 image; pixel value = base + 10*row + col.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_column_feeder;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] pix_in;
   logic              pix_in_valid;
   logic              pix_in_sof;
   logic              pix_in_ready;
   logic [DATA_W-1:0] left_out, current_out, right_out;
   logic              window_valid;
   logic              window_ready;
   logic              line_end;
   logic              sync_err;

   int n_vec  = 0;
   int n_miss = 0;
   logic [31:0] q_win [$];

   sobel_column_feeder #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk          (clk),
      .rst          (rst),
      .pix_in       (pix_in),
      .pix_in_valid (pix_in_valid),
      .pix_in_sof   (pix_in_sof),
      .pix_in_ready (pix_in_ready),
      .left_out     (left_out),
      .current_out  (current_out),
      .right_out    (right_out),
      .window_valid (window_valid),
      .window_ready (window_ready),
      .line_end     (line_end),
      .sync_err     (sync_err)
   );

   always #5 clk = ~clk;

   // Record every triple that will be consumed on the next rising edge
   always @(negedge clk) begin
      if (!rst && window_valid && window_ready)
         q_win.push_back({7'd0, line_end, left_out, current_out, right_out});
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one pixel and wait (bounded) for it to be accepted
   task automatic send(input logic [DATA_W-1:0] v, input logic s);
      bit ok = 1'b0;
      pix_in = v; pix_in_sof = s; pix_in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pix_in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      pix_in_valid = 1'b0; pix_in_sof = 1'b0;
      if (!ok) check_vec("send_timeout", 32'd0, 32'd1);
   endtask

   // Raster pixel p (0..15) of a frame offset by base
   task automatic send_pix(input int base, input int p, input logic s);
      send(DATA_W'(base + 10 * (p / IMG_W) + (p % IMG_W)), s);
   endtask

   // Expected triple k of a frame: centre row k/4+1, column k%4
   function automatic logic [31:0] exp_win(input int base, input int k);
      int r = k / IMG_W + 1;
      int c = k % IMG_W;
      logic le = (c == IMG_W - 1);
      return {7'd0, le, 8'(base + 10 * (r - 1) + c), 8'(base + 10 * r + c), 8'(base + 10 * (r + 1) + c)};
   endfunction

   task automatic check_frame(input int base);
      check_vec("frame_count", q_win.size(), (IMG_H - 2) * IMG_W);
      for (int k = 0; k < q_win.size() && k < (IMG_H - 2) * IMG_W; k++)
         check_vec($sformatf("frame%0d_triple%0d", base, k), q_win[k], exp_win(base, k));
   endtask

   initial begin
      rst = 1'b1; pix_in = '0; pix_in_valid = 1'b0; pix_in_sof = 1'b0; window_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check_vec("rst_ready",  pix_in_ready, 0);
      check_vec("rst_valid",  window_valid, 0);
      check_vec("rst_le",     line_end, 0);
      check_vec("rst_serr",   sync_err, 0);
      check_vec("rst_data",   {left_out, current_out, right_out}, 0);
      rst = 1'b0;

      // Frame 1: fill produces nothing, then the first triple 0/10/20
      q_win.delete();
      for (int p = 0; p < 8; p++) send_pix(0, p, 1'b0);
      check_vec("fill_none", q_win.size(), 0);
      check_vec("fill_valid", window_valid, 0);
      send_pix(0, 8, 1'b0);
      check_vec("first_valid", window_valid, 1);
      check_vec("first_triple", {left_out, current_out, right_out}, {8'd0, 8'd10, 8'd20});
      for (int p = 9; p < 16; p++) send_pix(0, p, 1'b0);
      @(posedge clk); #1;
      check_frame(0);
      check_vec("f1_drained", window_valid, 0);

      // Frame 2 back-to-back, values +100, SOF at (0,0) is not an error
      q_win.delete();
      for (int p = 0; p < 9; p++) send_pix(100, p, p == 0);
      check_vec("f2_first", {left_out, current_out, right_out}, {8'd100, 8'd110, 8'd120});
      for (int p = 9; p < 16; p++) send_pix(100, p, 1'b0);
      @(posedge clk); #1;
      check_frame(100);
      check_vec("f2_serr", sync_err, 0);

      // Frame 3: stall downstream on triple 1/11/21
      q_win.delete();
      for (int p = 0; p < 9; p++) send_pix(0, p, 1'b0);
      @(posedge clk); #1;
      window_ready = 1'b0;
      send_pix(0, 9, 1'b0);
      pix_in = 8'd22; pix_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_vec("bp_ready", pix_in_ready, 0);
         check_vec("bp_hold", {window_valid, left_out, current_out, right_out}, {1'b1, 8'd1, 8'd11, 8'd21});
      end
      @(posedge clk); #1;
      window_ready = 1'b1;
      pix_in_valid = 1'b0;
      for (int p = 10; p < 16; p++) send_pix(0, p, 1'b0);
      @(posedge clk); #1;
      check_frame(0);

      // Frame 4: SOF on pixel (1,2) restarts the frame at that pixel
      q_win.delete();
      for (int p = 0; p < 6; p++) send_pix(0, p, 1'b0);
      check_vec("pre_sof_serr", sync_err, 0);
      q_win.delete();
      send(8'd50, 1'b1);
      check_vec("sof_serr", sync_err, 1);
      for (int c = 1; c < 4; c++) send(8'(50 + c), 1'b0);
      for (int c = 0; c < 4; c++) send(8'(60 + c), 1'b0);
      check_vec("sof_fill_none", q_win.size(), 0);
      send(8'd70, 1'b0);
      check_vec("sof_resync", {window_valid, left_out, current_out, right_out}, {1'b1, 8'd50, 8'd60, 8'd70});

      // Reset while a triple (51/61/71) is held
      @(posedge clk); #1;
      window_ready = 1'b0;
      send(8'd71, 1'b0);
      check_vec("pre_rst_hold", {window_valid, left_out}, {1'b1, 8'd51});
      rst = 1'b1;
      @(negedge clk);
      check_vec("midrst_ready", pix_in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_vec("midrst_valid", window_valid, 0);
      check_vec("midrst_serr", sync_err, 0);
      window_ready = 1'b1;
      q_win.delete();
      for (int p = 0; p < 8; p++) send_pix(200, p, 1'b0);
      check_vec("postrst_none", q_win.size(), 0);
      send_pix(200, 8, 1'b0);
      check_vec("postrst_first", {window_valid, left_out, current_out, right_out}, {1'b1, 8'd200, 8'd210, 8'd220});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
